// File: rtl/pulse_filter_pkg.sv
// pulse_filter_pkg
//   Shared definitions for the pulse filter array: global filter mode
//   encodings, default parameter values and the transition-qualification
//   helper used by every channel.
package pulse_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_HIGH   = 2'b01,
        MODE_LOW    = 2'b10,
        MODE_BOTH   = 2'b11
    } mode_e;

    localparam int CH_NUM_DEF      = 32;
    localparam int THRES_W_DEF     = 22;  // threshold in 50 ns clock cycles
    localparam int SYNC_STAGES_DEF = 2;
    localparam int THRES_RST_DEF   = 20;  // 1 us
    localparam int CNT_W_DEF       = 16;

    // A rising transition is filtered under HIGH/BOTH, a falling one under
    // LOW/BOTH; anything else passes through with one cycle of latency.
    function automatic logic qualifies(input mode_e m, input logic rising);
        if (rising) return (m == MODE_HIGH) || (m == MODE_BOTH);
        else        return (m == MODE_LOW)  || (m == MODE_BOTH);
    endfunction

endpackage

// File: rtl/pulse_filter_chan.sv
// pulse_filter_chan
//   One pulse channel: input synchroniser, minimum-width filter counter,
//   registered level output and one-cycle edge strobes.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   pulse_i    raw asynchronous pulse input
//   en_i       channel enable; low forces output and counter to 0
//   mode_i     global filter mode
//   thres_i    effective threshold, already clamped to at least 1
//   pulse_o    filtered level
//   rise_o     strobe coincident with pulse_o 0->1
//   fall_o     strobe coincident with pulse_o 1->0
//   glitch_o   combinational: an in-progress count was abandoned this cycle
module pulse_filter_chan
    import pulse_filter_pkg::*;
#(
    parameter int THRES_W     = THRES_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_i,
    input  logic               en_i,
    input  mode_e              mode_i,
    input  logic [THRES_W-1:0] thres_i,
    output logic               pulse_o,
    output logic               rise_o,
    output logic               fall_o,
    output logic               glitch_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [THRES_W-1:0]     cnt_q, cnt_d;
    logic [THRES_W:0]       cnt_inc;
    logic                   glitch;

    assign sync_in = sync_q[SYNC_STAGES-1];
    // One bit wider so the compare stays correct for any threshold value.
    assign cnt_inc = {1'b0, cnt_q} + {{THRES_W{1'b0}}, 1'b1};

    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        glitch = 1'b0;
        if (!en_i) begin
            out_d = 1'b0;
            cnt_d = '0;
        end else if (sync_in == out_q) begin
            // Input came back before qualification: drop the count.
            cnt_d  = '0;
            glitch = (cnt_q != '0);
        end else if (!qualifies(mode_i, sync_in)) begin
            out_d = sync_in;
            cnt_d = '0;
        end else if (cnt_inc >= {1'b0, thres_i}) begin
            // Also catches a threshold lowered below the running count.
            out_d = sync_in;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc[THRES_W-1:0];
        end
        // A disable-forced drop must not strobe.
        rise_d = en_i &  out_d & ~out_q;
        fall_d = en_i & ~out_d &  out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pulse_o  = out_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign glitch_o = glitch;

endmodule

// File: rtl/pulse_filter_array.sv
// pulse_filter_array
//   CH_NUM independent pulse filters sharing one threshold register and one
//   global mode. Pulses shorter than the threshold (in clock cycles) are
//   suppressed on the selected edge polarity(ies).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pulse_in        raw asynchronous pulse inputs, one per channel
//   filter_thres    new threshold, captured when thres_load is high
//   thres_load      single-cycle load strobe for filter_thres
//   mode            00 bypass, 01 filter high, 10 filter low, 11 both
//   ch_en           per-channel enable
//   pulse_out       filtered levels
//   rise_pulse      per-channel 0->1 strobes
//   fall_pulse      per-channel 1->0 strobes
// Optional (macro PULSE_FILTER_GLITCH_CNT_EN):
//   glitch_sel      channel whose glitch counter is read
//   glitch_clr      clears every glitch counter
//   glitch_cnt      registered readout of the selected counter
module pulse_filter_array
    import pulse_filter_pkg::*;
#(
    parameter int CH_NUM      = CH_NUM_DEF,
    parameter int THRES_W     = THRES_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int THRES_RST   = THRES_RST_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH_NUM-1:0]  pulse_in,
    input  logic [THRES_W-1:0] filter_thres,
    input  logic               thres_load,
    input  logic [1:0]         mode,
    input  logic [CH_NUM-1:0]  ch_en,
    output logic [CH_NUM-1:0]  pulse_out,
    output logic [CH_NUM-1:0]  rise_pulse,
    output logic [CH_NUM-1:0]  fall_pulse
`ifdef PULSE_FILTER_GLITCH_CNT_EN
    ,
    input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] glitch_sel,
    input  logic               glitch_clr,
    output logic [CNT_W-1:0]   glitch_cnt
`endif
);

    logic [THRES_W-1:0] thres_q;
    logic [THRES_W-1:0] thres_eff;
    mode_e              mode_s;
    logic [CH_NUM-1:0]  glitch;

    assign mode_s = mode_e'(mode);
    // A zero threshold behaves as 1: OR in the LSB when the register is 0.
    assign thres_eff = thres_q | THRES_W'(thres_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             thres_q <= THRES_W'(THRES_RST);
        else if (thres_load) thres_q <= filter_thres;
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        pulse_filter_chan #(
            .THRES_W     (THRES_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .pulse_i  (pulse_in[g]),
            .en_i     (ch_en[g]),
            .mode_i   (mode_s),
            .thres_i  (thres_eff),
            .pulse_o  (pulse_out[g]),
            .rise_o   (rise_pulse[g]),
            .fall_o   (fall_pulse[g]),
            .glitch_o (glitch[g])
        );
    end

`ifdef PULSE_FILTER_GLITCH_CNT_EN
    logic [CH_NUM-1:0][CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0]             rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
            rd_q   <= '0;
        end else begin
            rd_q <= (int'(glitch_sel) < CH_NUM) ? gcnt_q[glitch_sel] : '0;
            for (int i = 0; i < CH_NUM; i++) begin
                if (glitch_clr)
                    gcnt_q[i] <= '0;
                else if (glitch[i] && (gcnt_q[i] != '1))
                    gcnt_q[i] <= gcnt_q[i] + 1'b1;
            end
        end
    end

    assign glitch_cnt = rd_q;
`else
    logic unused_glitch;
    assign unused_glitch = ^glitch;
`endif

endmodule

// File: tb/tb_pulse_filter_array.sv
module tb_pulse_filter_array;
    localparam int CH = 32;
    localparam int TW = 22;
    localparam int S  = 2;
    localparam int TR = 20;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] pulse_in = '0;
    logic [TW-1:0] filter_thres = '0;
    logic          thres_load = 1'b0;
    logic [1:0]    mode = 2'b11;
    logic [CH-1:0] ch_en = '1;
    logic [CH-1:0] pulse_out, rise_pulse, fall_pulse;
`ifdef PULSE_FILTER_GLITCH_CNT_EN
    logic [4:0]    glitch_sel = '0;
    logic          glitch_clr = 1'b0;
    logic [CW-1:0] glitch_cnt;
`endif

    pulse_filter_array #(.CH_NUM(CH), .THRES_W(TW), .SYNC_STAGES(S),
                         .THRES_RST(TR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .filter_thres(filter_thres),
        .thres_load(thres_load), .mode(mode), .ch_en(ch_en),
        .pulse_out(pulse_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
`ifdef PULSE_FILTER_GLITCH_CNT_EN
        , .glitch_sel(glitch_sel), .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Input history per synchroniser stage, a run length of consecutive
    // qualified-mismatch cycles per channel, and the resulting levels.
    logic [CH-1:0] m_hist [S];
    logic [CH-1:0] m_out, m_rise, m_fall;
    int            m_run [CH];
    int            m_thres;
    int            m_gl [CH];
    int            m_rd;

    task automatic model_step();
        int te;
        logic s, o, n;
        bit gl [CH];
        if (rst) begin
            for (int k = 0; k < S; k++) m_hist[k] = '0;
            m_out = '0; m_rise = '0; m_fall = '0;
            for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_gl[c] = 0; end
            m_thres = TR;
            m_rd = 0;
            return;
        end
        te = (m_thres < 1) ? 1 : m_thres;
        for (int c = 0; c < CH; c++) begin
            s = m_hist[S-1][c];
            o = m_out[c];
            n = o;
            gl[c] = 0;
            if (!ch_en[c]) begin
                n = 0; m_run[c] = 0;
            end else if (s == o) begin
                gl[c] = (m_run[c] > 0);
                m_run[c] = 0;
            end else if (s ? mode[0] : mode[1]) begin
                if (m_run[c] + 1 >= te) begin n = s; m_run[c] = 0; end
                else m_run[c] = m_run[c] + 1;
            end else begin
                n = s; m_run[c] = 0;
            end
            m_rise[c] = ch_en[c] && n && !o;
            m_fall[c] = ch_en[c] && !n && o;
            m_out[c]  = n;
        end
`ifdef PULSE_FILTER_GLITCH_CNT_EN
        m_rd = m_gl[glitch_sel];
        for (int c = 0; c < CH; c++) begin
            if (glitch_clr) m_gl[c] = 0;
            else if (gl[c] && m_gl[c] < (1 << CW) - 1) m_gl[c] = m_gl[c] + 1;
        end
`endif
        for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = pulse_in;
        if (thres_load) m_thres = int'(filter_thres);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // One compare per output every cycle, well clear of the clock edges.
    initial forever begin
        @(posedge clk);
        #3;
        if (cmp_en) begin
            chk("pulse_out", 64'(pulse_out), 64'(m_out));
            chk("rise_pulse", 64'(rise_pulse), 64'(m_rise));
            chk("fall_pulse", 64'(fall_pulse), 64'(m_fall));
`ifdef PULSE_FILTER_GLITCH_CNT_EN
            chk("glitch_cnt", 64'(glitch_cnt), 64'(m_rd));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setup(input int th, input logic [1:0] md);
        filter_thres = TW'(th);
        thres_load = 1'b1;
        tick(1);
        thres_load = 1'b0;
        mode = md;
        pulse_in = '0;
        ch_en = '1;
        tick(12);
    endtask

    initial begin
        int nr, nf;
        bit seen;
        tick(3);
        chk("reset_pulse_out", 64'(pulse_out), 64'd0);
        chk("reset_rise", 64'(rise_pulse), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick(2);

        // Short high pulse, thres 4, filter both: suppressed, one glitch.
        setup(4, 2'b11);
`ifdef PULSE_FILTER_GLITCH_CNT_EN
        glitch_clr = 1'b1; tick(1); glitch_clr = 1'b0; glitch_sel = 5'd0; tick(2);
`endif
        pulse_in[0] = 1'b1;
        seen = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 3) pulse_in[0] = 1'b0;
            seen |= pulse_out[0] | rise_pulse[0] | fall_pulse[0];
        end
        chk("short_pulse_quiet", 64'(seen), 64'd0);
`ifdef PULSE_FILTER_GLITCH_CNT_EN
        chk("short_pulse_glitch_cnt", 64'(glitch_cnt), 64'd1);
`endif

        // 10-cycle pulse: edges appear 6 cycles after each pin edge.
        pulse_in[0] = 1'b1;
        nr = 0; nf = 0;
        for (int k = 1; k <= 22; k++) begin
            tick(1);
            nr += int'(rise_pulse[0]);
            nf += int'(fall_pulse[0]);
            if (k == 5)  chk("long_rise_n5", 64'(pulse_out[0]), 64'd0);
            if (k == 6)  chk("long_rise_n6", 64'(pulse_out[0]), 64'd1);
            if (k == 10) pulse_in[0] = 1'b0;
            if (k == 15) chk("long_fall_n15", 64'(pulse_out[0]), 64'd1);
            if (k == 16) chk("long_fall_n16", 64'(pulse_out[0]), 64'd0);
        end
        chk("long_rise_count", 64'(nr), 64'd1);
        chk("long_fall_count", 64'(nf), 64'd1);

        // High-only filtering: low gap passes in 3 cycles, re-rise filtered.
        setup(4, 2'b01);
        pulse_in[1] = 1'b1;
        tick(12);
        pulse_in[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 2) begin
                chk("gap_n2", 64'(pulse_out[1]), 64'd1);
                pulse_in[1] = 1'b1;
            end
            if (k == 3) chk("gap_drop_n3", 64'(pulse_out[1]), 64'd0);
            if (k == 7) chk("gap_rerise_n7", 64'(pulse_out[1]), 64'd0);
            if (k == 8) chk("gap_rerise_n8", 64'(pulse_out[1]), 64'd1);
        end

        // Threshold lowered from 8 to 3 with ch5 at count 5.
        setup(8, 2'b11);
        pulse_in[5] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == 7) begin filter_thres = TW'(3); thres_load = 1'b1; end
            if (k == 8) begin
                thres_load = 1'b0;
                chk("thres_drop_n8", 64'(pulse_out[5]), 64'd0);
            end
            if (k == 9) chk("thres_drop_n9", 64'(pulse_out[5]), 64'd1);
        end

        // Disable a high channel: output drops without a fall strobe.
        setup(4, 2'b11);
        pulse_in[7] = 1'b1;
        tick(10);
        chk("dis_pre_high", 64'(pulse_out[7]), 64'd1);
        ch_en[7] = 1'b0;
        tick(1);
        chk("dis_out", 64'(pulse_out[7]), 64'd0);
        chk("dis_no_fall", 64'(fall_pulse[7]), 64'd0);
        ch_en[7] = 1'b1;
        pulse_in[7] = 1'b0;
        tick(10);

        // Reset mid-count on every channel, then default threshold of 20.
        pulse_in = '1;
        tick(4);
        rst = 1'b1;
        #1;
        chk("rst_async_out", 64'(pulse_out), 64'd0);
        chk("rst_async_rise", 64'(rise_pulse), 64'd0);
        tick(2);
        rst = 1'b0;
        mode = 2'b11;
        tick(1);
        chk("rst_release_rise", 64'(rise_pulse), 64'd0);
        chk("rst_release_fall", 64'(fall_pulse), 64'd0);
        pulse_in = '0;
        tick(30);
        pulse_in = '1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 21) chk("rst_thres_n21", 64'(pulse_out), 64'd0);
            if (k == 22) chk("rst_thres_n22", 64'(pulse_out), 64'(32'hFFFF_FFFF));
            if (k == 25) pulse_in = '0;
        end
        tick(30);

        // Randomized traffic checked every cycle against the model.
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 99) < 6) pulse_in[c] = ~pulse_in[c];
            thres_load = ($urandom_range(0, 99) < 2);
            if (thres_load) filter_thres = TW'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 1) begin
                int idx;
                idx = int'($urandom_range(0, CH - 1));
                ch_en[idx] = ~ch_en[idx];
            end
`ifdef PULSE_FILTER_GLITCH_CNT_EN
            glitch_sel = 5'($urandom_range(0, CH - 1));
            glitch_clr = ($urandom_range(0, 199) < 1);
`endif
            rst = ($urandom_range(0, 999) < 2);
            tick(1);
        end
        rst = 1'b0;
        tick(3);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
